// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the duty cycle of an asynchronous PWM input whose
// period is 2^WIDTH clk cycles. Each window opens on a rising edge of the
// synchronized input and spans 2^WIDTH samples. The result is a WIDTH-bit
// high-cycle count, saturated at 2^WIDTH-1. If no rising edge arrives within
// the timeout, the current input level is reported and stuck is raised.
// Optional macro GLITCH_FILTER_EN inserts a 3-sample majority filter after the
// synchronizer. This suppresses single-cycle pulses and adds 2 cycles of latency.
module pwm_duty_meter #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic             valid,
  output logic             stuck,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE
  } state_t;

  localparam logic [WIDTH:0] WIN_LEN = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_c;
  logic                   pwm_d_q;
  logic                   rise;
  logic [WIDTH:0]         win_cnt_q, win_cnt_d;
  logic [WIDTH:0]         high_cnt_q, high_cnt_d;
  logic [WIDTH:0]         tmo_cnt_q, tmo_cnt_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic                   stuck_q, stuck_d;
  logic                   valid_q, valid_d;

  // Multi-flop synchronizer for the asynchronous PWM input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  logic [1:0] tap_q;
  logic       filt_q;

  // Majority of the three most recent samples; a lone one-cycle pulse never wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      tap_q  <= {tap_q[0], pwm_s};
      filt_q <= (pwm_s & tap_q[0]) | (pwm_s & tap_q[1]) | (tap_q[0] & tap_q[1]);
    end
  end

  assign pwm_c = filt_q;
`else
  assign pwm_c = pwm_s;
`endif

  assign rise = pwm_c & ~pwm_d_q;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pwm_d_q    <= 1'b0;
      win_cnt_q  <= '0;
      high_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      duty_q     <= '0;
      stuck_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwm_d_q    <= pwm_c;
      win_cnt_q  <= win_cnt_d;
      high_cnt_q <= high_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      duty_q     <= duty_d;
      stuck_q    <= stuck_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state logic: arm, window counting, timeout and result publication
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    high_cnt_d = high_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    duty_d     = duty_q;
    stuck_d    = stuck_q;
    valid_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_ARM;
          tmo_cnt_d = '0;
        end
      end
      S_ARM: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (rise) begin
          state_d    = S_MEASURE;
          win_cnt_d  = ONE;
          high_cnt_d = ONE;
        end else if (tmo_cnt_q == WIN_LEN) begin
          duty_d    = pwm_c ? '1 : '0;
          stuck_d   = 1'b1;
          valid_d   = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + ONE;
        end
      end
      S_MEASURE: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (win_cnt_q == WIN_LEN) begin
          // high_cnt can reach 2^WIDTH when every sample was high; clamp it
          duty_d    = high_cnt_q[WIDTH] ? '1 : high_cnt_q[WIDTH-1:0];
          stuck_d   = 1'b0;
          valid_d   = 1'b1;
          state_d   = S_ARM;
          tmo_cnt_d = '0;
        end else begin
          win_cnt_d  = win_cnt_q + ONE;
          high_cnt_d = high_cnt_q + {{WIDTH{1'b0}}, pwm_c};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign duty  = duty_q;
  assign valid = valid_q;
  assign stuck = stuck_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. A reference model records every sampled input.
// From the window start and timeout rules it derives the expected outputs,
// and a window result is the plain sum of the samples it covers.
module tb_pwm_duty_meter;
  localparam int W = 8;
  localparam int S = 2;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] duty;
  logic         valid, stuck, busy;

  pwm_duty_meter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .en(en), .pwm_in(pwm_in),
    .duty(duty), .valid(valid), .stuck(stuck), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit hist[$];         // pwm_in as sampled at each clock edge since reset
  int mode = 0;        // 0 idle, 1 waiting for edge, 2 inside a window
  int arm_start = 0;
  int win_start = 0;
  int e_duty = 0;
  bit e_valid = 0, e_stuck = 0, e_busy = 0;

  function automatic bit raw_s(input int i);
    int k;
    k = i - S + 1;
    return (k >= 0 && k < hist.size()) ? hist[k] : 1'b0;
  endfunction

  // Sample level seen by edge detection and counting during cycle i
  function automatic bit s_at(input int i);
`ifdef GLITCH_FILTER_EN
    int ones;
    ones = int'(raw_s(i - 1)) + int'(raw_s(i - 2)) + int'(raw_s(i - 3));
    return ones >= 2;
`else
    return raw_s(i);
`endif
  endfunction

  task automatic model_reset();
    hist.delete();
    mode = 0;
    e_duty = 0; e_valid = 0; e_stuck = 0; e_busy = 0;
  endtask

  // Predict outputs after the next clock edge, given inputs now stable
  task automatic model_step();
    int c, sum;
    c = hist.size() - 1;
    e_valid = 0;
    if (mode != 0 && !en) begin
      mode = 0;
    end else if (mode == 0) begin
      if (en) begin mode = 1; arm_start = c + 1; end
    end else if (mode == 1) begin
      if (s_at(c) && !s_at(c - 1)) begin
        mode = 2; win_start = c;
      end else if (c - arm_start == N) begin
        e_duty = s_at(c) ? N - 1 : 0; e_stuck = 1; e_valid = 1; arm_start = c + 1;
      end
    end else begin
      if (c - win_start == N) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(s_at(win_start + k));
        e_duty = (sum > N - 1) ? N - 1 : sum;
        e_stuck = 0; e_valid = 1; mode = 1; arm_start = c + 1;
      end
    end
    hist.push_back(pwm_in);
    e_busy = (mode != 0);
  endtask

  // Monitor bookkeeping for the literal checks
  int cyc_n = 0, valid_cnt = 0, last_valid_cyc = 0, last_gap = 0;
  int last_duty = 0;
  bit last_stuck = 0;

  // Compare process: every cycle against the model
  always @(negedge clk) begin
    cyc_n++;
    if (!reset) begin
      model_reset();
      chk("rst_duty", duty, 0);
      chk("rst_valid", valid, 0);
      chk("rst_stuck", stuck, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("duty", duty, e_duty);
      chk("valid", valid, e_valid);
      chk("stuck", stuck, e_stuck);
      chk("busy", busy, e_busy);
      if (valid === 1'b1) begin
        last_gap = cyc_n - last_valid_cyc;
        last_valid_cyc = cyc_n;
        valid_cnt++;
        last_duty = duty;
        last_stuck = stuck;
      end
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  int phase_g = 0;

  task automatic cyc(input bit e, input bit p);
    @(posedge clk);
    #1;
    en = e;
    pwm_in = p;
  endtask

  task automatic run_pwm(input int d, input int n, input int glitch);
    bit p;
    for (int i = 0; i < n; i++) begin
      p = (phase_g < d);
      if (glitch >= 0 && phase_g == glitch) p = 1'b0;
      cyc(1'b1, p);
      phase_g = (phase_g + 1) % N;
    end
  endtask

  task automatic pwm_until_valid(input int d, input int budget, output bit ok);
    int start;
    start = valid_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      run_pwm(d, 1, -1);
      if (valid_cnt != start) begin ok = 1; break; end
    end
  endtask

  initial begin
    int v0, d;
    bit ok;
    phase_g = $urandom_range(0, N - 1);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);

    // 1: duty 0x40
    v0 = valid_cnt;
    run_pwm('h40, 1100, -1);
    chk("t1_duty", last_duty, 'h40);
    chk("t1_stuck", last_stuck, 0);
    chk("t1_some_valids", (valid_cnt - v0) >= 2, 1);

    // 2: duty 0xFF
    run_pwm('hFF, 1100, -1);
    chk("t2_duty", last_duty, 'hFF);
    chk("t2_stuck", last_stuck, 0);

    // 3: input held low -> periodic timeouts
    repeat (1000) cyc(1'b1, 1'b0);
    chk("t3_duty", last_duty, 0);
    chk("t3_stuck", last_stuck, 1);
    chk("t3_period", last_gap, N + 1);

    // 4: input held high -> saturated window, then timeout high
    repeat (270) cyc(1'b1, 1'b1);
    chk("t4_win_duty", last_duty, 'hFF);
    chk("t4_win_stuck", last_stuck, 0);
    repeat (300) cyc(1'b1, 1'b1);
    chk("t4_tmo_duty", last_duty, 'hFF);
    chk("t4_tmo_stuck", last_stuck, 1);

    // 5: en dropped mid-window
    phase_g = 0;
    pwm_until_valid('h40, 800, ok);
    chk("t5_valid_seen", ok, 1);
    pwm_until_valid('h40, 800, ok);
    chk("t5_duty_before", last_duty, 'h40);
    while (phase_g != 0) run_pwm('h40, 1, -1);
    run_pwm('h40, 100, -1);
    v0 = valid_cnt;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_duty_hold", duty, 'h40);
    repeat (300) cyc(1'b0, 1'b0);
    chk("t5_no_valid", valid_cnt - v0, 0);

    // 6: async reset mid-window
    pwm_until_valid('h40, 800, ok);
    chk("t6_valid_seen", ok, 1);
    while (phase_g != 0) run_pwm('h40, 1, -1);
    run_pwm('h40, 60, -1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_duty", duty, 0);
    chk("t6_valid", valid, 0);
    chk("t6_stuck", stuck, 0);
    chk("t6_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 7: single-cycle low glitch in a 0x80 PWM
    run_pwm('h80, 1100, 50);
`ifdef GLITCH_FILTER_EN
    chk("t7_glitch_duty", last_duty, 'h80);
`else
    chk("t7_glitch_duty", last_duty, 'h7F);
`endif

    // Random duty codes
    for (int r = 0; r < 5; r++) begin
      d = $urandom_range(3, 254);
      run_pwm(d, 1100, -1);
      chk("rand_duty", last_duty, d);
    end

    // Random noise with occasional enable drops; checked by the model only
    for (int i = 0; i < 1500; i++) cyc($urandom_range(0, 59) != 0, 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
